mul_seq: RTL

Sequential shift-add multiplier with dti handshakes on both operands and the result. It is the multiplicative counterpart to the combinational `div` and sits in the same arithmetic library. It trades `DIN1_W` cycles of latency for a single adder of width `DIN0_W+1`, so it does not infer a full combinational multiplier. Operand signedness is selected per input, with the same parameter scheme as the other arithmetic blocks.

---
 rtl/mul_seq_pkg.sv | 11 +
 rtl/mul_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_seq_pkg;

  // Controller states: waiting for operands, iterating, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_seq_state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier. Both operands are taken together on one
// joint handshake; the product appears DIN1_W+1 cycles later and is held
// until the consumer accepts it. Signed operands are reduced to magnitudes,
// multiplied unsigned, and the result is negated at the end when needed.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int DIN0_W      = 16,
  parameter int DIN1_W      = 16,
  parameter int DOUT_W      = DIN0_W + DIN1_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN0_W-1:0] din0_data,
  input  logic              din0_valid,
  output logic              din0_ready,
  input  logic [DIN1_W-1:0] din1_data,
  input  logic              din1_valid,
  output logic              din1_ready,
  output logic [DOUT_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int CNT_W = $clog2(DIN1_W + 1);

  // The product width is fixed by the operand widths; anything else is a
  // configuration mistake that must stop elaboration.
  if (DOUT_W != DIN0_W + DIN1_W) begin : g_bad_dout_w
    $error("mul_seq: DOUT_W must equal DIN0_W+DIN1_W");
  end

  mul_seq_state_t    state_reg;
  logic [DIN0_W-1:0] mcand_reg;
  logic [DIN1_W-1:0] mplier_reg;
  logic [DOUT_W-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              neg_reg;
  logic [DOUT_W-1:0] dout_data_reg;
  logic              dout_valid_reg;

  logic              take;
  logic              sign0, sign1;
  logic [DIN0_W-1:0] mag0;
  logic [DIN1_W-1:0] mag1;
  logic [DIN0_W-1:0] addend;
  logic [DIN0_W:0]   sum;
  logic [DOUT_W:0]   shifted;
  logic [DOUT_W-1:0] acc_next;
  logic [DOUT_W-1:0] acc_neg;
  logic              last_iter;

  // Operands are only ever consumed as a pair, and only while idle and out
  // of reset, so a lone valid never produces a one-sided handshake.
  assign take       = rst & (state_reg == IDLE) & din0_valid & din1_valid;
  assign din0_ready = take;
  assign din1_ready = take;

  // Magnitude of each operand; the most negative value maps onto its
  // unsigned bit pattern, which is exactly the right magnitude.
  assign sign0 = (DIN0_SIGNED != 0) & din0_data[DIN0_W-1];
  assign sign1 = (DIN1_SIGNED != 0) & din1_data[DIN1_W-1];
  assign mag0  = sign0 ? (~din0_data + DIN0_W'(1'b1)) : din0_data;
  assign mag1  = sign1 ? (~din1_data + DIN1_W'(1'b1)) : din1_data;

  // One iteration: conditionally add the multiplicand into the upper
  // DIN0_W+1 bits (carry kept), then shift the whole accumulator right.
  assign addend    = mplier_reg[0] ? mcand_reg : '0;
  assign sum       = {1'b0, acc_reg[DOUT_W-1 -: DIN0_W]} + {1'b0, addend};
  assign shifted   = {sum, acc_reg[DIN1_W-1:0]};
  assign acc_next  = shifted[DOUT_W:1];
  assign acc_neg   = ~acc_next + DOUT_W'(1'b1);
  assign last_iter = (cnt_reg == CNT_W'(DIN1_W - 1));

  // Controller and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      neg_reg        <= 1'b0;
      dout_data_reg  <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take) begin
            mcand_reg  <= mag0;
            mplier_reg <= mag1;
            neg_reg    <= sign0 ^ sign1;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1'b1);
          if (last_iter) begin
            dout_data_reg  <= neg_reg ? acc_neg : acc_next;
            dout_valid_reg <= 1'b1;
            cnt_reg        <= '0;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dout_data  = dout_data_reg;
  assign dout_valid = dout_valid_reg;

endmodule
